// File: rtl/cornet_bus_pkg.sv
// Shared definitions for the system-memory bus arbiter.
// Contents: FSM state encoding, owner ids, default bus widths and a
// saturating 4-bit counter helper.
package cornet_bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  localparam logic OWNER_VID = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } bus_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    if (value == 4'hF) begin
      return 4'hF;
    end else begin
      return value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single synchronous system-memory port between the video
// fetch unit and the CPU. Video has fixed priority, except that the CPU wins
// once it has lost CPU_MAX_WAIT arbitrations in a row. Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> ACK -> IDLE.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   vid_req, vid_addr              video level request and address
//   vid_rd_data, vid_ack           video read data (held) and 1-cycle ack
//   cpu_req, cpu_wr, cpu_addr,
//   cpu_wr_data                    CPU level request, direction, addr, data
//   cpu_rd_data, cpu_ack           CPU read data (held) and 1-cycle ack
//   mem_addr, mem_wr_en,
//   mem_wr_data, mem_rd_data       memory port (all outputs registered)
module mem_bus_arbiter
  import cornet_bus_pkg::*;
#(
  parameter int ADDR_W       = BUS_ADDR_W,
  parameter int MEM_LATENCY  = 2,
  parameter int CPU_MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic [BUS_DATA_W-1:0] vid_rd_data,
  output logic                  vid_ack,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [BUS_DATA_W-1:0] cpu_wr_data,
  output logic [BUS_DATA_W-1:0] cpu_rd_data,
  output logic                  cpu_ack,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wr_en,
  output logic [BUS_DATA_W-1:0] mem_wr_data,
  input  logic [BUS_DATA_W-1:0] mem_rd_data
);

  // WAIT counts down from L-1 to 0; the zero cycle is the data-valid cycle.
  localparam logic [2:0] LAT_LAST_C = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] MAX_WAIT_C = 4'(CPU_MAX_WAIT);

  bus_state_e state_r;
  bus_state_e next_state_s;
  logic [2:0] lat_cnt_r;
  logic [3:0] starve_cnt_r;
  logic       owner_r;
  logic       wr_r;
  logic       grant_cpu_s;
  logic       grant_vid_s;

  // Arbitration: only meaningful in IDLE; starved CPU beats video.
  always_comb begin
    grant_cpu_s = 1'b0;
    grant_vid_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (cpu_req && (starve_cnt_r >= MAX_WAIT_C)) begin
        grant_cpu_s = 1'b1;
      end else if (vid_req) begin
        grant_vid_s = 1'b1;
      end else if (cpu_req) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
      end
    end else begin
      grant_vid_s = 1'b0;
    end
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_cpu_s || grant_vid_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (lat_cnt_r == 3'd0) begin
          next_state_s = ST_ACK;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_ACK:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Access datapath: latch on grant, strobe write, capture data, pulse ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r     <= OWNER_VID;
      wr_r        <= 1'b0;
      lat_cnt_r   <= 3'd0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'h00;
      vid_rd_data <= 8'h00;
      cpu_rd_data <= 8'h00;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless set below.
      mem_wr_en <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_cpu_s) begin
            owner_r     <= OWNER_CPU;
            wr_r        <= cpu_wr;
            mem_addr    <= cpu_addr;
            mem_wr_data <= cpu_wr_data;
            mem_wr_en   <= cpu_wr;
          end else if (grant_vid_s) begin
            owner_r  <= OWNER_VID;
            wr_r     <= 1'b0;
            mem_addr <= vid_addr;
          end else begin
            owner_r <= owner_r;
          end
        end
        ST_ISSUE: begin
          lat_cnt_r <= LAT_LAST_C;
        end
        ST_WAIT: begin
          if (lat_cnt_r == 3'd0) begin
            // Ack is raised on entry to ACK so it is high for that cycle only.
            if (owner_r == OWNER_CPU) begin
              cpu_ack <= 1'b1;
              if (!wr_r) begin
                cpu_rd_data <= mem_rd_data;
              end else begin
                cpu_rd_data <= cpu_rd_data;
              end
            end else begin
              vid_ack     <= 1'b1;
              vid_rd_data <= mem_rd_data;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        ST_ACK: begin
          lat_cnt_r <= 3'd0;
        end
        default: begin
          lat_cnt_r <= 3'd0;
        end
      endcase
    end
  end

  // Starvation counter: lost CPU arbitrations since the last CPU grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_cpu_s) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_vid_s && cpu_req) begin
      starve_cnt_r <= sat_inc4(starve_cnt_r);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule
